// File: rtl/fact_job_scheduler.sv
// rtl/fact_job_scheduler.sv - round-robin job scheduler sharing one factorial engine
// Grants one requester at a time, drives the engine handshake, times out hung jobs.
module fact_job_scheduler #(
  parameter int NREQ    = 4,
  parameter int NW      = 8,
  parameter int RW      = 32,
  parameter int TIMEOUT = 1024,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW     = $clog2(TIMEOUT) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*NW-1:0] req_n,
  output logic [NREQ-1:0]    gnt,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [RW-1:0]      rsp_result,
  output logic               rsp_err,
  output logic               busy,
  output logic               eng_load,
  output logic [NW-1:0]      eng_n,
  output logic               eng_dack,
  output logic               eng_rst,
  input  logic               eng_pre,
  input  logic               eng_done,
  input  logic [RW-1:0]      eng_result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_ABORT,
    S_RESP,
    S_ACK
  } state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] rr;
  logic [IDW-1:0] id;
  logic [IDW-1:0] pick;
  logic           pick_ok;
  logic           start;
  logic [CW-1:0]  cnt;
  logic [RW-1:0]  result;
  logic           err;

  // First asserted request at or after the rr pointer, wrapping around.
  always_comb begin
    int j;
    pick    = '0;
    pick_ok = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!pick_ok && req[IDW'(j)]) begin
        pick_ok = 1'b1;
        pick    = IDW'(j);
      end
    end
  end

  assign start = (state == S_IDLE) && eng_pre && pick_ok && !rst;

  always_comb begin
    state_nx   = state;
    gnt        = '0;
    rsp_valid  = 1'b0;
    eng_load   = 1'b0;
    eng_dack   = 1'b0;
    eng_rst    = 1'b0;
    busy       = (state != S_IDLE);
    rsp_id     = id;
    rsp_result = result;
    rsp_err    = err;
    case (state)
      S_IDLE: begin
        if (start) begin
          gnt      = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        eng_load = 1'b1;
        state_nx = S_RUN;
      end
      S_RUN: begin
        // A result arriving on the timeout cycle still counts as success.
        if (eng_done) state_nx = S_RESP;
        else if (cnt == CW'(TIMEOUT - 1)) state_nx = S_ABORT;
      end
      S_ABORT: begin
        eng_rst  = 1'b1;
        state_nx = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = err ? S_IDLE : S_ACK;
      end
      S_ACK: begin
        eng_dack = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      rr     <= '0;
      id     <= '0;
      eng_n  <= '0;
      result <= '0;
      err    <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            id    <= pick;
            eng_n <= req_n[int'(pick)*NW +: NW];
          end
        end
        S_LOAD: cnt <= '0;
        S_RUN: begin
          cnt <= cnt + CW'(1);
          if (eng_done) begin
            result <= eng_result;
            err    <= 1'b0;
          end
        end
        S_ABORT: begin
          result <= '0;
          err    <= 1'b1;
        end
        S_RESP: begin
          if (rsp_ready) rr <= (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_job_scheduler.sv
// tb/tb_fact_job_scheduler.sv - scoreboard bench for fact_job_scheduler
// Behavioural engine and round-robin model; monitor checks every cycle at negedge.
module tb_fact_job_scheduler;
  localparam int NREQ = 4, NW = 8, RW = 32, TIMEOUT = 16, IDW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*NW-1:0] req_n = '0;
  logic rsp_ready = 1'b0;
  logic [NREQ-1:0] gnt;
  logic rsp_valid, rsp_err, busy, eng_load, eng_dack, eng_rst;
  logic [IDW-1:0] rsp_id;
  logic [RW-1:0] rsp_result;
  logic [NW-1:0] eng_n;
  logic eng_pre, eng_done;
  logic [RW-1:0] eng_result;

  fact_job_scheduler #(.NREQ(NREQ), .NW(NW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_n(req_n), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
    .eng_load(eng_load), .eng_n(eng_n), .eng_dack(eng_dack), .eng_rst(eng_rst),
    .eng_pre(eng_pre), .eng_done(eng_done), .eng_result(eng_result)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] fact(input int n);
    logic [RW-1:0] r;
    r = 1;
    for (int i = 2; i <= n; i++) r = r * RW'(i);
    return r;
  endfunction

  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return NREQ'(1) << ((p + k) % NREQ);
    return '0;
  endfunction

  // Behavioural engine: idle -> computing -> result held until dack.
  int e_state = 0, e_cnt = 0;
  bit e_hang = 0, next_hang = 0, hold_busy = 0, force_hang = 0, rand_hang = 0;
  logic [RW-1:0] e_val = '0;

  always @(posedge clk) begin
    if (rst || eng_rst) e_state <= 0;
    else case (e_state)
      0: if (eng_load) begin
        e_val   <= fact(int'(eng_n));
        e_cnt   <= $urandom_range(1, 6);
        e_hang  <= next_hang;
        e_state <= 1;
      end
      1: if (!e_hang) begin
        if (e_cnt <= 1) e_state <= 2;
        else e_cnt <= e_cnt - 1;
      end
      2: if (eng_dack) e_state <= 0;
      default: e_state <= 0;
    endcase
  end

  assign eng_pre    = (e_state == 0) && !hold_busy;
  assign eng_done   = (e_state == 2);
  assign eng_result = (e_state == 2) ? e_val : 32'hDEAD_BEEF;

  typedef struct {int id; int n; logic [RW-1:0] res; bit err;} exp_t;
  exp_t q[$];
  exp_t e;

  int cyc_n = 0, mrr = 0, abort_at = -1;
  int jobs_done = 0, grants = 0, rst_pulses = 0, dack_cnt = 0;
  int grant_log[$];
  bit job_active = 0, dack_exp = 0;
  logic [NREQ-1:0] last_gnt = '0, prev_gnt = '0, eg;
  bit prev_valid = 0, prev_ready = 0, prev_done = 0, prev_engrst = 0, prev_dack = 0;
  logic [IDW-1:0] h_id;
  logic [RW-1:0] h_res;
  logic h_err;
  int last_id = 0;
  logic [RW-1:0] last_res = '0;
  logic last_err = 0;

  always @(negedge clk) begin
    cyc_n++;
    last_gnt = gnt;
    if (rst) begin
      q.delete();
      mrr = 0; job_active = 0; dack_exp = 0; abort_at = -1;
      prev_gnt = '0; prev_valid = 0; prev_ready = 0; prev_done = 0; prev_engrst = 0; prev_dack = 0;
    end else begin
      eg = (eng_pre && !job_active) ? rr_pick(req, mrr) : '0;
      check("gnt", gnt, eg);
      if (gnt != 0) begin
        for (int i = 0; i < NREQ; i++) if (gnt[i]) begin
          e.id = i; e.n = int'(req_n[i*NW +: NW]); e.res = fact(e.n); e.err = 0;
          q.push_back(e);
          grant_log.push_back(i);
        end
        job_active = 1;
        grants++;
      end
      check("eng_load", eng_load, prev_gnt != 0);
      if (eng_load && q.size() > 0) begin
        check("eng_n", eng_n, q[0].n);
        next_hang = force_hang || (rand_hang && $urandom_range(0, 5) == 0);
        if (next_hang) begin
          e = q[0]; e.err = 1; e.res = '0; q[0] = e;
          abort_at = cyc_n + 1 + TIMEOUT;
        end
      end
      check("eng_rst", eng_rst, cyc_n == abort_at);
      if (eng_rst) rst_pulses++;
      check("eng_dack", eng_dack, dack_exp);
      if (eng_dack) dack_cnt++;
      dack_exp = 0;
      if (prev_valid && !prev_ready) begin
        check("hold_valid", rsp_valid, 1);
        check("hold_id", rsp_id, h_id);
        check("hold_result", rsp_result, h_res);
        check("hold_err", rsp_err, h_err);
      end
      if (rsp_valid && !prev_valid) begin
        check("rsp_cause", prev_done || prev_engrst, 1);
        check("rsp_expected", q.size(), 1);
      end
      if (prev_done && !prev_valid && !prev_dack) check("done_to_rsp", rsp_valid, 1);
      if (rsp_valid && rsp_ready) begin
        check("rsp_pending", q.size() != 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_result", rsp_result, e.res);
          check("rsp_err", rsp_err, e.err);
          dack_exp = !e.err;
          mrr = (e.id + 1) % NREQ;
        end
        last_id = int'(rsp_id); last_res = rsp_result; last_err = rsp_err;
        job_active = 0; abort_at = -1; jobs_done++;
      end
      prev_gnt = gnt; prev_valid = rsp_valid; prev_ready = rsp_ready;
      prev_done = eng_done; prev_engrst = eng_rst; prev_dack = eng_dack;
      h_id = rsp_id; h_res = rsp_result; h_err = rsp_err;
    end
  end

  bit auto_req = 0, auto_ready = 0;
  logic [NREQ-1:0] keep_mask = '0, rearm = '0;

  task automatic step();
    @(posedge clk); #1;
    req = req | rearm;
    rearm = '0;
    for (int i = 0; i < NREQ; i++) if (last_gnt[i]) begin
      req[i] = 1'b0;
      req_n[i*NW +: NW] = NW'($urandom_range(0, 12));
      if (keep_mask[i]) rearm[i] = 1'b1;
    end
    if (auto_req)
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && !rearm[i] && $urandom_range(0, 3) == 0) begin
          req_n[i*NW +: NW] = NW'($urandom_range(0, 12));
          req[i] = 1'b1;
        end
    if (auto_ready) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_jobs(input int target, input int budget, input string name);
    int n = 0;
    while (jobs_done < target && n < budget) begin step(); n++; end
    check(name, jobs_done >= target, 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((req != 0 || rearm != 0 || busy || q.size() != 0) && n < budget) begin step(); n++; end
    check("drain", n < budget, 1);
  endtask

  task automatic set_req(input int i, input int n);
    req_n[i*NW +: NW] = NW'(n);
    req[i] = 1'b1;
  endtask

  int j0, g0, p0, d0, n;
  int rr_exp[6];

  initial begin
    rr_exp = '{0, 1, 3, 0, 1, 3};
    rst = 1;
    repeat (3) step();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_outputs", {gnt, rsp_valid, rsp_id, rsp_result, rsp_err, eng_load, eng_n, eng_dack, eng_rst}, 0);
    step();
    rst = 0;
    rsp_ready = 1;

    // single job: 5! = 120
    j0 = jobs_done;
    set_req(0, 5);
    wait_jobs(j0 + 1, 100, "single_done");
    check("single_result", last_res, 120);
    check("single_id", last_id, 0);
    check("single_err", last_err, 0);

    // round robin with 1011 held and re-raised
    rst = 1; step(); rst = 0;
    grant_log.delete();
    keep_mask = 4'b1011;
    set_req(0, $urandom_range(0, 12));
    set_req(1, $urandom_range(0, 12));
    set_req(3, $urandom_range(0, 12));
    n = 0;
    while (grant_log.size() < 6 && n < 500) begin step(); n++; end
    keep_mask = '0;
    drain(500);
    check("rr_count", grant_log.size() >= 6, 1);
    for (int k = 0; k < 6; k++)
      if (k < grant_log.size()) check($sformatf("rr_order%0d", k), grant_log[k], rr_exp[k]);

    // backpressure
    rsp_ready = 0;
    j0 = jobs_done; d0 = dack_cnt;
    set_req(1, 4);
    n = 0;
    while (!rsp_valid && n < 100) begin step(); n++; end
    check("bp_valid", rsp_valid, 1);
    repeat (10) step();
    check("bp_no_dack", dack_cnt - d0, 0);
    rsp_ready = 1;
    repeat (4) step();
    check("bp_done", jobs_done - j0, 1);
    check("bp_result", last_res, 24);
    check("bp_one_dack", dack_cnt - d0, 1);

    // timeout
    force_hang = 1;
    j0 = jobs_done; p0 = rst_pulses; d0 = dack_cnt;
    set_req(2, 3);
    wait_jobs(j0 + 1, 100, "to_done");
    force_hang = 0;
    check("to_rst_pulse", rst_pulses - p0, 1);
    check("to_err", last_err, 1);
    check("to_result", last_res, 0);
    repeat (2) step();
    check("to_no_dack", dack_cnt - d0, 0);

    // engine not idle
    hold_busy = 1;
    g0 = grants; j0 = jobs_done;
    set_req(2, 7);
    repeat (8) step();
    check("nopre_no_gnt", grants - g0, 0);
    hold_busy = 0;
    wait_jobs(j0 + 1, 100, "nopre_done");
    check("nopre_id", last_id, 2);

    // reset while running
    force_hang = 1;
    j0 = jobs_done;
    set_req(0, 6);
    n = 0;
    while (!eng_load && n < 50) begin step(); n++; end
    repeat (3) step();
    check("mid_busy", busy, 1);
    rst = 1; step(); rst = 0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_outputs", {gnt, rsp_valid, rsp_id, rsp_result, rsp_err, eng_load, eng_n, eng_dack, eng_rst}, 0);
    force_hang = 0;
    step();
    set_req(1, 7);
    wait_jobs(j0 + 1, 100, "mid_next_done");
    check("mid_next_id", last_id, 1);
    check("mid_next_result", last_res, 5040);

    // random traffic
    rand_hang = 1; auto_req = 1; auto_ready = 1;
    wait_jobs(jobs_done + 30, 6000, "rand_jobs");
    auto_req = 0; auto_ready = 0; rsp_ready = 1;
    drain(3000);
    rand_hang = 0;
    check("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fact_job_scheduler.md
Name: fact_job_scheduler

Overview:
- Shares one factorial engine (controller plus datapath) among NREQ requesters.
- Arbitrates round-robin and issues each job's operand to the engine.
- Drives the engine load/dack handshake, times out hung jobs and returns tagged results on a shared response channel.
- Sits between the requester fabric and the single factorial engine instance.

Parameters:
NREQ, 4, number of requesters (2..16)
NW, 8, operand width (n)
RW, 32, result width
TIMEOUT, 1024, max cycles in RUN before abort (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req  in  NREQ  per-requester job request, held until granted
req_n  in  NREQ*NW  packed operands; slice i belongs to req[i]
gnt  out  NREQ  one-hot, one-cycle pulse; slice i of req_n is sampled in that cycle
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  $clog2(NREQ)  requester index of response
rsp_result  out  RW  factorial result, 0 on error
rsp_err  out  1  job aborted by timeout
busy  out  1  job in flight (state != IDLE)
eng_load  out  1  engine load strobe
eng_n  out  NW  operand to engine datapath, registered
eng_dack  out  1  engine result acknowledge
eng_rst  out  1  engine abort reset, ORed with system reset at engine
eng_pre  in  1  engine idle
eng_done  in  1  engine result valid
eng_result  in  RW  engine datapath result

Behaviour:
- Reset:
  - state=IDLE, rr pointer=0 (req[0] highest priority).
  - All outputs 0; id/n/result registers 0; timeout counter 0.
- States: IDLE, LOAD, RUN, ABORT, RESP, ACK.
- IDLE:
  - If eng_pre && |req, grant the first asserted req at or after the rr pointer, wrapping.
  - gnt[i]=1 for that cycle only; latch id=i and eng_n=req_n[i]; next=LOAD.
  - If eng_pre=0, no grant is issued, regardless of req.
- LOAD: eng_load=1 for exactly one cycle; counter cleared; next=RUN.
- RUN:
  - eng_load=0; counter increments each cycle.
  - If eng_done: latch eng_result, err=0, next=RESP.
  - Else if counter==TIMEOUT-1: next=ABORT.
  - If eng_done and the timeout fall in the same cycle, eng_done wins.
- ABORT: eng_rst=1 for one cycle; result=0, err=1; next=RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result, rsp_err held stable until the handshake.
  - On rsp_valid && rsp_ready: rr pointer = id+1 mod NREQ.
  - Then next=ACK if err=0, else next=IDLE.
- ACK: eng_dack=1 for exactly one cycle; next=IDLE.
  - The engine returns to its idle state on the same edge, so eng_pre is high the following cycle.
- Latency:
  - Grant to eng_load: 1 cycle.
  - eng_done to rsp_valid: 1 cycle.
  - rsp handshake to eng_dack: 1 cycle.
  - Minimum gap between successive grants: ACK cycle plus one IDLE cycle.
- eng_dack is never asserted while rsp_valid && !rsp_ready (engine stays in its result-valid state under backpressure).
- req deasserted before grant: no job issued, no error.
- req_n changes after grant are ignored.
- rst mid-job (any state): immediate return to IDLE.
  - Outputs cleared next cycle; in-flight job dropped with no response.
  - rr pointer returns to 0.
- rsp_id width: max(1,$clog2(NREQ)).

Test Plan:
- Single job: req=4'b0001, req_n[0]=5, engine model computes n! -> gnt=4'b0001 one cycle, eng_load one cycle later, rsp_valid with rsp_id=0, rsp_result=120, rsp_err=0; eng_dack one cycle after rsp_ready.
- Round-robin: req=4'b1011 held continuously, each serviced job's req dropped after grant then re-raised -> grant order 0,1,3,0,1,3; no requester granted twice while another is waiting.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable, eng_dack=0 throughout; single eng_dack one cycle after rsp_ready rises.
- Timeout: engine model never asserts eng_done, TIMEOUT=16 -> eng_rst pulse 16 cycles after RUN entry, then rsp_err=1, rsp_result=0, no eng_dack; next grant after eng_pre.
- Engine not idle: eng_pre forced 0 with req=4'b0100 -> no gnt; gnt[2] the cycle eng_pre rises.
- Reset mid-RUN: assert rst for 1 cycle during RUN -> busy=0, all outputs 0, no rsp_valid for dropped job; next req=4'b0010 granted normally.
